// File: rtl/brisc_pkg.sv
// Shared definitions for the brisc core and its cache-to-memory interface.
//   XLEN        : address width in bits
//   LINE_BITS   : cache line width in bits
//   MEM_LATENCY : default main-memory latency in cycles
//   OFFSET_BITS : byte-offset bits inside one line
//   mem_req_t   : request bundle (we, addr, wdata)
//   mem_resp_t  : response bundle (we, rdata)
package brisc_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned LINE_BITS   = 128;
  localparam int unsigned MEM_LATENCY = 5;
  localparam int unsigned OFFSET_BITS = $clog2(LINE_BITS / 8);

  typedef struct packed {
    logic                 we;
    logic [XLEN-1:0]      addr;
    logic [LINE_BITS-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic                 we;
    logic [LINE_BITS-1:0] rdata;
  } mem_resp_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous line RAM, written to map onto block RAM.
//   clk_i   : clock
//   en_i    : access enable (read or write this edge)
//   we_i    : 1 = write wdata_i, 0 = read only
//   addr_i  : line index
//   wdata_i : line to write
//   rdata_o : registered read data, updated only on enabled edges
// Contents and the read register are deliberately not reset.
module mem_array #(
  parameter int unsigned Width = 128,
  parameter int unsigned Depth = 4096,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Read-before-write: on a write the read register picks up the old line,
  // which the responder masks off anyway.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Main-memory model answering cache-line requests with a fixed latency.
//   clk, reset_n            : clock, asynchronous active-low reset
//   req_valid/req_ready     : request handshake (one outstanding request)
//   req_we/addr/wdata       : request fields, sampled only at accept
//   resp_valid/resp_ready   : response handshake
//   resp_we/resp_rdata      : response fields, stable while resp_valid is high
module mem_responder
  import brisc_pkg::*;
#(
  parameter int unsigned LINE_BITS = brisc_pkg::LINE_BITS,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LATENCY   = brisc_pkg::MEM_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [LINE_BITS-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_we,
  output logic [LINE_BITS-1:0] resp_rdata
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic                 resp_we_q, resp_we_d;
  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 ram_en;
  logic [LINE_BITS-1:0] ram_rdata;

  // Bits outside the line index are intentionally ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    resp_we_d = resp_we_q;
    ram_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          idx_d   = req_addr[OFFSET_BITS +: IdxW];
          wdata_d = req_wdata;
          cnt_d   = CntW'(LATENCY - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          // Array access happens on the BUSY-exit edge.
          ram_en    = 1'b1;
          resp_we_d = we_q;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Handshake outputs are registered copies of the next-state decode, so
    // req_ready stays low during reset and rises on the first edge after it.
    req_ready_d  = (state_d == StIdle);
    resp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      resp_we_q    <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      resp_we_q    <= resp_we_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  mem_array #(
    .Width(LINE_BITS),
    .Depth(DEPTH),
    .AddrW(IdxW)
  ) u_mem_array (
    .clk_i  (clk),
    .en_i   (ram_en),
    .we_i   (we_q),
    .addr_i (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  // The RAM read register doubles as the response register; it only changes
  // on BUSY exit, so it is stable throughout RESP. Masked to zero otherwise.
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_we    = resp_we_q;
  assign resp_rdata = (resp_valid_q && !resp_we_q) ? ram_rdata : '0;

endmodule
